// File: rtl/dcache_port_arbiter_pkg.sv
// dcache_port_arbiter_pkg: shared request types and widths for the D-cache port arbiter.
// Rev 1.0
`default_nettype none

package dcache_port_arbiter_pkg;

  localparam int LSU_ADDR_W = 64;
  localparam int LSU_DATA_W = 64;
  localparam int LSU_STRB_W = LSU_DATA_W / 8;

  typedef struct packed {
    logic                  is_write;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
    logic [LSU_STRB_W-1:0] wstrb;
  } dc_req_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned m);
    return (v + 1) % m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_port_arbiter_rr_arbiter.sv
// dcache_port_arbiter_rr_arbiter: round-robin one-hot grant, pointer advances past each winner.
// Rev 1.0
`default_nettype none

module dcache_port_arbiter_rr_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             found;
  logic [31:0]      idx;

  always_comb begin
    gnt_o    = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % 32'(NUM_REQ);
      if (!found && en_i && req_i[idx[PTR_W-1:0]]) begin
        found                  = 1'b1;
        gnt_o[idx[PTR_W-1:0]] = 1'b1;
        rr_ptr_d               = PTR_W'(wrap_inc(idx, NUM_REQ));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares one L1 D-cache port among NUM_REQ requesters with in-order response routing.
// Rev 1.0
`default_nettype none

module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0]              req_is_write_i,
  input  logic [NUM_REQ*LSU_ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*LSU_DATA_W-1:0]   req_wdata_i,
  input  logic [NUM_REQ*LSU_STRB_W-1:0]   req_wstrb_i,
  input  logic [NUM_REQ*TAG_W-1:0]        req_tag_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [LSU_DATA_W-1:0]           rsp_rdata_o,
  output logic [TAG_W-1:0]                rsp_tag_o,
  output logic                            dc_req_valid_o,
  input  logic                            dc_req_ready_i,
  output logic                            dc_req_is_write_o,
  output logic [LSU_ADDR_W-1:0]           dc_req_addr_o,
  output logic [LSU_DATA_W-1:0]           dc_req_wdata_o,
  output logic [LSU_STRB_W-1:0]           dc_req_wstrb_o,
  input  logic                            dc_rsp_valid_i,
  input  logic [LSU_DATA_W-1:0]           dc_rsp_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                            err_o
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [TAG_W-1:0] tag;
  } rsp_route_t;

  dc_req_t                 stage_q, stage_d;
  logic                    dc_req_valid_q, dc_req_valid_d;
  rsp_route_t              fifo_q [MAX_OUTSTANDING];
  rsp_route_t              fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [LSU_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [TAG_W-1:0]        rsp_tag_q, rsp_tag_d;
  logic                    err_q, err_d;

  logic                    out_free, can_grant, push, pop;
  logic [NUM_REQ-1:0]      gnt;
  rsp_route_t              head, push_route;

  assign out_free  = !dc_req_valid_q || dc_req_ready_i;
  // A response arriving this cycle frees a credit, so a full FIFO may still grant.
  assign can_grant = out_free && ((cnt_q < CNT_W'(MAX_OUTSTANDING)) || dc_rsp_valid_i);

  dcache_port_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_valid_i),
    .en_i  (can_grant),
    .gnt_o (gnt)
  );

  assign push = |gnt;
  assign pop  = dc_rsp_valid_i && (cnt_q != '0);
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    stage_d        = stage_q;
    dc_req_valid_d = dc_req_valid_q;
    push_route     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        stage_d.is_write = req_is_write_i[i];
        stage_d.addr     = req_addr_i[i*LSU_ADDR_W +: LSU_ADDR_W];
        stage_d.wdata    = req_wdata_i[i*LSU_DATA_W +: LSU_DATA_W];
        stage_d.wstrb    = req_wstrb_i[i*LSU_STRB_W +: LSU_STRB_W];
        push_route.id    = ID_W'(i);
        push_route.tag   = req_tag_i[i*TAG_W +: TAG_W];
      end
    end
    if (push)                dc_req_valid_d = 1'b1;
    else if (dc_req_ready_i) dc_req_valid_d = 1'b0;

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_route;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_tag_d   = rsp_tag_q;
    if (pop) begin
      rsp_valid_d[head.id] = 1'b1;
      rsp_rdata_d          = dc_rsp_rdata_i;
      rsp_tag_d            = head.tag;
    end

    err_d = err_q || (dc_rsp_valid_i && (cnt_q == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q        <= '0;
      dc_req_valid_q <= 1'b0;
      fifo_q         <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
      rsp_tag_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      stage_q        <= stage_d;
      dc_req_valid_q <= dc_req_valid_d;
      fifo_q         <= fifo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_tag_q      <= rsp_tag_d;
      err_q          <= err_d;
    end
  end

  assign req_ready_o       = gnt;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_rdata_o       = rsp_rdata_q;
  assign rsp_tag_o         = rsp_tag_q;
  assign dc_req_valid_o    = dc_req_valid_q;
  assign dc_req_is_write_o = stage_q.is_write;
  assign dc_req_addr_o     = stage_q.addr;
  assign dc_req_wdata_o    = stage_q.wdata;
  assign dc_req_wstrb_o    = stage_q.wstrb;
  assign outstanding_o     = cnt_q;
  assign err_o             = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
// Rev 1.0
`default_nettype none

module tb_dcache_port_arbiter;

  localparam int N    = 3;
  localparam int MAXO = 4;
  localparam int TW   = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_is_write;
  logic [N*64-1:0] req_addr, req_wdata;
  logic [N*8-1:0] req_wstrb;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]   req_ready, rsp_valid;
  logic [63:0]    rsp_rdata;
  logic [TW-1:0]  rsp_tag;
  logic           dc_req_valid, dc_req_ready, dc_req_is_write;
  logic [63:0]    dc_req_addr, dc_req_wdata;
  logic [7:0]     dc_req_wstrb;
  logic           dc_rsp_valid;
  logic [63:0]    dc_rsp_rdata;
  logic [2:0]     outstanding;
  logic           err;

  int checks = 0;
  int errors = 0;

  dcache_port_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO), .TAG_W(TW)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_is_write_i    (req_is_write),
    .req_addr_i        (req_addr),
    .req_wdata_i       (req_wdata),
    .req_wstrb_i       (req_wstrb),
    .req_tag_i         (req_tag),
    .rsp_valid_o       (rsp_valid),
    .rsp_rdata_o       (rsp_rdata),
    .rsp_tag_o         (rsp_tag),
    .dc_req_valid_o    (dc_req_valid),
    .dc_req_ready_i    (dc_req_ready),
    .dc_req_is_write_o (dc_req_is_write),
    .dc_req_addr_o     (dc_req_addr),
    .dc_req_wdata_o    (dc_req_wdata),
    .dc_req_wstrb_o    (dc_req_wstrb),
    .dc_rsp_valid_i    (dc_rsp_valid),
    .dc_rsp_rdata_i    (dc_rsp_rdata),
    .outstanding_o     (outstanding),
    .err_o             (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid    = '0;
    req_is_write = '0;
    req_addr     = '0;
    req_wdata    = '0;
    req_wstrb    = '0;
    req_tag      = '0;
    dc_req_ready = 1'b0;
    dc_rsp_valid = 1'b0;
    dc_rsp_rdata = '0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [63:0] a, input logic [63:0] wd,
                         input logic [7:0] st, input logic [7:0] tg);
    req_valid[i]          = 1'b1;
    req_is_write[i]       = wr;
    req_addr[i*64 +: 64]  = a;
    req_wdata[i*64 +: 64] = wd;
    req_wstrb[i*8 +: 8]   = st;
    req_tag[i*TW +: TW]   = tg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b expected 000", req_ready); end
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_dc_req_valid: got %b expected 0", dc_req_valid); end
    checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 000", rsp_valid); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (rsp_rdata !== 64'h0 || rsp_tag !== 8'h0) begin errors++; $display("FAIL reset_rsp_data: got %h/%h expected 0/0", rsp_rdata, rsp_tag); end
    checks++; if (dc_req_addr !== 64'h0) begin errors++; $display("FAIL reset_dc_addr: got %h expected 0", dc_req_addr); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    dc_req_ready = 1'b1;
    set_req(0, 1'b0, 64'h1000, 64'h0, 8'h00, 8'h11);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_grant: got %b expected 001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 64'h1000 || dc_req_is_write !== 1'b0)
      begin errors++; $display("FAIL single_dc_req: got v=%b a=%h w=%b expected v=1 a=1000 w=0", dc_req_valid, dc_req_addr, dc_req_is_write); end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding: got %0d expected 1", outstanding); end
    tick();
    checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL single_stage_clear: got %b expected 0", dc_req_valid); end
    dc_rsp_valid = 1'b1;
    dc_rsp_rdata = 64'hDEAD;
    tick();
    dc_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 3'b001 || rsp_rdata !== 64'hDEAD || rsp_tag !== 8'h11)
      begin errors++; $display("FAIL single_rsp: got v=%b d=%h t=%h expected v=001 d=dead t=11", rsp_valid, rsp_rdata, rsp_tag); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_drained: got %0d expected 0", outstanding); end
    tick();
    checks++; if (rsp_valid !== 3'b000 || rsp_rdata !== 64'hDEAD) begin errors++; $display("FAIL single_rsp_pulse: got v=%b d=%h expected v=000 d=dead", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_round_robin();
    do_reset();
    dc_req_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 64'(32'h100 * i), 64'h0, 8'h00, 8'(8'h20 + i));
    for (int c = 0; c < 6; c++) begin
      dc_rsp_valid = (c >= 2);
      dc_rsp_rdata = 64'(c + 32'h40);
      #1;
      checks++; if (req_ready !== 3'(1 << (c % 3))) begin errors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, 3'(1 << (c % 3))); end
      tick();
      checks++; if (dc_req_addr !== 64'(32'h100 * (c % 3))) begin errors++; $display("FAIL rr_dc_addr c=%0d: got %h expected %h", c, dc_req_addr, 32'h100 * (c % 3)); end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 3'(1 << ((c - 2) % 3)) || rsp_tag !== 8'(8'h20 + (c - 2) % 3) || rsp_rdata !== 64'(c + 32'h40)) begin
          errors++;
          $display("FAIL rr_rsp c=%0d: got v=%b t=%h d=%h expected v=%b t=%h d=%h", c, rsp_valid, rsp_tag, rsp_rdata,
                   3'(1 << ((c - 2) % 3)), 8'(8'h20 + (c - 2) % 3), c + 32'h40);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dc_req_ready = 1'b0;
    set_req(0, 1'b1, 64'h2000, 64'hAAAA_5555_0000_1111, 8'hF0, 8'h01);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL bp_first_grant: got %b expected 001", req_ready); end
    tick();
    req_valid = '0;
    set_req(1, 1'b0, 64'h3000, 64'h0, 8'h00, 8'h02);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== 3'b000 || dc_req_valid !== 1'b1 || dc_req_addr !== 64'h2000 || dc_req_is_write !== 1'b1 ||
          dc_req_wdata !== 64'hAAAA_5555_0000_1111 || dc_req_wstrb !== 8'hF0) begin
        errors++;
        $display("FAIL bp_hold c=%0d: got rdy=%b v=%b a=%h d=%h s=%h expected rdy=000 v=1 a=2000 d=aaaa555500001111 s=f0",
                 c, req_ready, dc_req_valid, dc_req_addr, dc_req_wdata, dc_req_wstrb);
      end
      tick();
    end
    dc_req_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL bp_release_grant: got %b expected 010", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 64'h3000) begin errors++; $display("FAIL bp_next_req: got v=%b a=%h expected v=1 a=3000", dc_req_valid, dc_req_addr); end
  endtask

  task automatic test_full();
    int grants;
    do_reset();
    dc_req_ready = 1'b1;
    grants = 0;
    set_req(0, 1'b0, 64'h4000, 64'h0, 8'h00, 8'h33);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (req_ready[0]) grants++;
      tick();
    end
    checks++; if (grants != MAXO) begin errors++; $display("FAIL full_grant_count: got %0d expected %0d", grants, MAXO); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding: got %0d expected 4", outstanding); end
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL full_blocked: got %b expected 000", req_ready); end
    dc_rsp_valid = 1'b1;
    dc_rsp_rdata = 64'h77;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL full_grant_on_rsp: got %b expected 001", req_ready); end
    tick();
    dc_rsp_valid = 1'b0;
    req_valid    = '0;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_push_pop: got %0d expected 4", outstanding); end
    checks++; if (rsp_valid !== 3'b001 || rsp_tag !== 8'h33) begin errors++; $display("FAIL full_rsp: got v=%b t=%h expected v=001 t=33", rsp_valid, rsp_tag); end
  endtask

  task automatic test_order_mix();
    do_reset();
    dc_req_ready = 1'b1;
    set_req(2, 1'b1, 64'h5000, 64'hCAFE, 8'h0F, 8'h52);
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL mix_ptw_grant: got %b expected 100", req_ready); end
    tick();
    req_valid = '0;
    set_req(1, 1'b0, 64'h6000, 64'h0, 8'h00, 8'h61);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL mix_lsu1_grant: got %b expected 010", req_ready); end
    checks++; if (dc_req_is_write !== 1'b1 || dc_req_wstrb !== 8'h0F || dc_req_addr !== 64'h5000 || dc_req_wdata !== 64'hCAFE)
      begin errors++; $display("FAIL mix_ptw_stage: got w=%b s=%h a=%h d=%h expected w=1 s=0f a=5000 d=cafe", dc_req_is_write, dc_req_wstrb, dc_req_addr, dc_req_wdata); end
    tick();
    req_valid = '0;
    checks++; if (dc_req_is_write !== 1'b0 || dc_req_addr !== 64'h6000) begin errors++; $display("FAIL mix_lsu1_stage: got w=%b a=%h expected w=0 a=6000", dc_req_is_write, dc_req_addr); end
    tick();
    dc_rsp_valid = 1'b1;
    dc_rsp_rdata = 64'h1111;
    tick();
    dc_rsp_rdata = 64'h2222;
    checks++; if (rsp_valid !== 3'b100 || rsp_tag !== 8'h52 || rsp_rdata !== 64'h1111)
      begin errors++; $display("FAIL mix_rsp_ptw: got v=%b t=%h d=%h expected v=100 t=52 d=1111", rsp_valid, rsp_tag, rsp_rdata); end
    tick();
    dc_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 3'b010 || rsp_tag !== 8'h61 || rsp_rdata !== 64'h2222)
      begin errors++; $display("FAIL mix_rsp_lsu1: got v=%b t=%h d=%h expected v=010 t=61 d=2222", rsp_valid, rsp_tag, rsp_rdata); end
  endtask

  task automatic test_err_reset();
    do_reset();
    dc_rsp_valid = 1'b1;
    dc_rsp_rdata = 64'hBAD;
    tick();
    dc_rsp_valid = 1'b0;
    checks++; if (err !== 1'b1 || rsp_valid !== 3'b000 || outstanding !== 3'd0)
      begin errors++; $display("FAIL err_spurious: got e=%b v=%b o=%0d expected e=1 v=000 o=0", err, rsp_valid, outstanding); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    dc_req_ready = 1'b1;
    set_req(0, 1'b0, 64'h7000, 64'h0, 8'h00, 8'h70);
    for (int c = 0; c < 3; c++) tick();
    req_valid = '0;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL err_inflight: got %0d expected 3", outstanding); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (outstanding !== 3'd0 || err !== 1'b0 || dc_req_valid !== 1'b0 || rsp_valid !== 3'b000)
      begin errors++; $display("FAIL err_mid_reset: got o=%0d e=%b v=%b r=%b expected o=0 e=0 v=0 r=000", outstanding, err, dc_req_valid, rsp_valid); end
  endtask

  task automatic test_random();
    bit          p_valid [N];
    logic        p_wr    [N];
    logic [63:0] p_addr  [N];
    logic [63:0] p_wdata [N];
    logic [7:0]  p_wstrb [N];
    logic [7:0]  p_tag   [N];
    int          q_id  [$];
    int          q_tag [$];
    int          m_rr, c_pend, win, idx, rid;
    bit          m_sv, free, credit;
    logic        m_swr;
    logic [63:0] m_saddr, m_swd, m_rdata;
    logic [7:0]  m_sst, m_tag;
    logic [2:0]  m_rsp, exp_gnt;

    do_reset();
    m_rr = 0; c_pend = 0; m_sv = 0; m_rsp = '0; m_rdata = '0; m_tag = '0;
    m_swr = 0; m_saddr = '0; m_swd = '0; m_sst = '0;
    for (int i = 0; i < N; i++) p_valid[i] = 0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && ($urandom_range(0, 1) == 1)) begin
          p_valid[i] = 1;
          p_wr[i]    = 1'($urandom_range(0, 1));
          p_addr[i]  = {$urandom, $urandom};
          p_wdata[i] = {$urandom, $urandom};
          p_wstrb[i] = 8'($urandom);
          p_tag[i]   = 8'($urandom);
        end
        req_valid[i] = p_valid[i];
        if (p_valid[i]) set_req(i, p_wr[i], p_addr[i], p_wdata[i], p_wstrb[i], p_tag[i]);
      end
      dc_req_ready = ($urandom_range(0, 3) != 0);
      dc_rsp_valid = (c_pend > 0) && ($urandom_range(0, 1) == 1);
      dc_rsp_rdata = {$urandom, $urandom};
      #1;

      free    = !m_sv || dc_req_ready;
      credit  = (q_id.size() < MAXO) || dc_rsp_valid;
      win     = -1;
      if (free && credit) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (win < 0 && p_valid[idx]) win = idx;
        end
      end
      exp_gnt = (win >= 0) ? 3'(1 << win) : 3'b000;

      checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL rand_grant cyc=%0d: got %b expected %b", cyc, req_ready, exp_gnt); end
      checks++; if (dc_req_valid !== m_sv) begin errors++; $display("FAIL rand_dc_valid cyc=%0d: got %b expected %b", cyc, dc_req_valid, m_sv); end
      if (m_sv) begin
        checks++;
        if (dc_req_addr !== m_saddr || dc_req_wdata !== m_swd || dc_req_is_write !== m_swr || (m_swr && dc_req_wstrb !== m_sst)) begin
          errors++;
          $display("FAIL rand_dc_fields cyc=%0d: got a=%h d=%h w=%b s=%h expected a=%h d=%h w=%b s=%h", cyc,
                   dc_req_addr, dc_req_wdata, dc_req_is_write, dc_req_wstrb, m_saddr, m_swd, m_swr, m_sst);
        end
      end
      checks++; if (rsp_valid !== m_rsp) begin errors++; $display("FAIL rand_rsp_valid cyc=%0d: got %b expected %b", cyc, rsp_valid, m_rsp); end
      if (m_rsp != 3'b000) begin
        checks++; if (rsp_rdata !== m_rdata || rsp_tag !== m_tag)
          begin errors++; $display("FAIL rand_rsp_data cyc=%0d: got d=%h t=%h expected d=%h t=%h", cyc, rsp_rdata, rsp_tag, m_rdata, m_tag); end
      end
      checks++; if (outstanding !== 3'(q_id.size())) begin errors++; $display("FAIL rand_outstanding cyc=%0d: got %0d expected %0d", cyc, outstanding, q_id.size()); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err cyc=%0d: got %b expected 0", cyc, err); end

      if (m_sv && dc_req_ready) c_pend++;
      if (dc_rsp_valid) begin
        c_pend--;
        rid     = q_id.pop_front();
        m_rsp   = 3'(1 << rid);
        m_tag   = 8'(q_tag.pop_front());
        m_rdata = dc_rsp_rdata;
      end else begin
        m_rsp = 3'b000;
      end
      if (win >= 0) begin
        q_id.push_back(win);
        q_tag.push_back(int'(p_tag[win]));
        m_sv    = 1;
        m_swr   = p_wr[win];
        m_saddr = p_addr[win];
        m_swd   = p_wdata[win];
        m_sst   = p_wstrb[win];
        m_rr    = (win + 1) % N;
        p_valid[win] = 0;
      end else if (dc_req_ready) begin
        m_sv = 0;
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full();
    test_order_mix();
    test_err_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
